// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Eight-requester bus arbiter built around a three-state FSM
//   (IDLE / GRANT / RELEASE). The priority scheme is selectable:
//   fixed priority (highest index wins) or descending round-robin.
//   A hold counter can revoke a grant once MAX_HOLD grant cycles have
//   elapsed; setting MAX_HOLD to 0 disables this timeout.
//
// Ports
//   clk       : single clock; all state changes on its rising edge
//   rst_n     : synchronous active-low reset
//   req[7:0]  : level-sensitive request lines, bit n = requester n
//   mask[7:0] : 1 makes the corresponding requester ineligible
//   rr_en     : 1 = round-robin priority, 0 = fixed priority
//   lock      : 1 keeps the current holder from being timed out
//   grant     : one-hot grant, or all zero when no grant is active
//   grant_idx : index of the granted requester; 4'h8 when none
//   busy      : 1 in any state other than IDLE
//   timeout   : one-cycle pulse when the hold limit revokes a grant
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter logic [7:0] MAX_HOLD = 8'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       rr_en,
  input  logic       lock,
  output logic [7:0] grant,
  output logic [3:0] grant_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] grant_q, grant_d;
  logic [3:0] grant_idx_q, grant_idx_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  logic [7:0] elig_s;
  logic [2:0] win_s;
  logic [8:0] cnt_inc_s;
  logic       hold_hit_s;

  // Winner search. Round-robin starts one below the last winner and
  // descends with wrap, so the last winner itself is examined last.
  // Fixed priority simply descends from index 7.
  function automatic logic [2:0] pick_winner(input logic [7:0] elig,
                                             input logic       rr,
                                             input logic [2:0] last);
    logic [2:0] cand;
    logic [2:0] win;
    logic       found;
    win   = 3'd0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (rr) begin
        cand = last - 3'(k);
      end else begin
        cand = 3'(8 - k);
      end
      if (!found && elig[cand]) begin
        win   = cand;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  // Next-state, hold counter and next-output computation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    grant_d     = 8'h00;
    grant_idx_d = 4'h8;
    busy_d      = 1'b0;

    elig_s     = req & ~mask;
    win_s      = pick_winner(elig_s, rr_en, last_q);
    // 9-bit increment so the comparison cannot wrap at 255.
    cnt_inc_s  = {1'b0, cnt_q} + 9'd1;
    hold_hit_s = (MAX_HOLD != 8'd0) && (cnt_inc_s >= {1'b0, MAX_HOLD});

    case (state_q)
      IDLE, RELEASE: begin
        if (elig_s != 8'h00) begin
          state_d = GRANT;
          idx_d   = win_s;
          last_d  = win_s;
          cnt_d   = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Voluntary release has precedence and never raises timeout.
        if (!req[idx_q] || mask[idx_q]) begin
          state_d = RELEASE;
        end else if (hold_hit_s && !lock) begin
          state_d   = RELEASE;
          timeout_d = 1'b1;
        end else begin
          state_d = GRANT;
          // Under lock the counter parks at MAX_HOLD so that dropping
          // lock revokes on the very next edge.
          if (hold_hit_s) begin
            cnt_d = MAX_HOLD;
          end else begin
            cnt_d = cnt_inc_s[7:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == GRANT) begin
      grant_d     = 8'h01 << idx_d;
      grant_idx_d = {1'b0, idx_d};
    end else begin
      grant_d     = 8'h00;
      grant_idx_d = 4'h8;
    end

    if (state_d != IDLE) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // State, counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      last_q      <= 3'd0;
      cnt_q       <= 8'd0;
      grant_q     <= 8'h00;
      grant_idx_q <= 4'h8;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       rr_en;
  logic       lock;

  logic [7:0] g0, g2, g4;
  logic [3:0] i0, i2, i4;
  logic       b0, b2, b4;
  logic       t0, t2, t4;

  int checks;
  int errors;

  bus_arbiter #(.MAX_HOLD(8'd64)) u_def (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .rr_en(rr_en), .lock(lock),
    .grant(g0), .grant_idx(i0), .busy(b0), .timeout(t0));

  bus_arbiter #(.MAX_HOLD(8'd2)) u_h2 (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .rr_en(rr_en), .lock(lock),
    .grant(g2), .grant_idx(i2), .busy(b2), .timeout(t2));

  bus_arbiter #(.MAX_HOLD(8'd4)) u_h4 (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .rr_en(rr_en), .lock(lock),
    .grant(g4), .grant_idx(i4), .busy(b4), .timeout(t4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       rr_en;
    logic       lock;
    logic [7:0] eg;
    logic [3:0] ei;
    logic       eb;
    logic       et;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  task automatic chk(input string nm,
                     input logic [7:0] g, input logic [3:0] gi, input logic b, input logic t,
                     input logic [7:0] eg, input logic [3:0] egi, input logic eb, input logic et);
    checks++;
    if ({g, gi, b, t} !== {eg, egi, eb, et}) begin
      errors++;
      $display("FAIL %s: got grant=%h idx=%h busy=%b timeout=%b, expected grant=%h idx=%h busy=%b timeout=%b",
               nm, g, gi, b, t, eg, egi, eb, et);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] one;
    int         e;
    checks = 0;
    errors = 0;
    one    = 8'h01;
    rst_n  = 1'b0;
    req    = 8'h00;
    mask   = 8'h00;
    rr_en  = 1'b0;
    lock   = 1'b0;

    //            rst  req    mask   rr    lock  grant  idx   busy  to
    vecs[0]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 4'h8, 1'b0, 1'b0}; // reset state
    vecs[1]  = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 4'h8, 1'b0, 1'b0}; // no req: idle
    vecs[2]  = '{1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 4'h8, 1'b0, 1'b0}; // all masked
    vecs[3]  = '{1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 4'h8, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 4'h8, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 4'h8, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h24, 8'h00, 1'b0, 1'b0, 8'h20, 4'h5, 1'b1, 1'b0}; // fixed: 5 wins
    vecs[7]  = '{1'b1, 8'h24, 8'h00, 1'b0, 1'b0, 8'h20, 4'h5, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 4'h8, 1'b1, 1'b0}; // drop 5: release
    vecs[9]  = '{1'b1, 8'h04, 8'h00, 1'b0, 1'b0, 8'h04, 4'h2, 1'b1, 1'b0}; // then 2
    vecs[10] = '{1'b1, 8'h0C, 8'h00, 1'b1, 1'b0, 8'h04, 4'h2, 1'b1, 1'b0}; // rr_en flip: held
    vecs[11] = '{1'b1, 8'h08, 8'h00, 1'b1, 1'b0, 8'h00, 4'h8, 1'b1, 1'b0}; // drop 2
    vecs[12] = '{1'b1, 8'h08, 8'h00, 1'b1, 1'b0, 8'h08, 4'h3, 1'b1, 1'b0}; // grant 3
    vecs[13] = '{1'b1, 8'h08, 8'h08, 1'b1, 1'b0, 8'h00, 4'h8, 1'b1, 1'b0}; // mask 3: release, no timeout
    vecs[14] = '{1'b1, 8'h08, 8'h08, 1'b1, 1'b0, 8'h00, 4'h8, 1'b0, 1'b0}; // to idle
    vecs[15] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 4'h8, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 8'h11, 8'h00, 1'b1, 1'b0, 8'h01, 4'h0, 1'b1, 1'b0}; // rr from last=3: 0
    vecs[17] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 4'h8, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 8'h11, 8'h00, 1'b1, 1'b0, 8'h10, 4'h4, 1'b1, 1'b0}; // rr from last=0: 4
    vecs[19] = '{1'b1, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 4'h8, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 8'h40, 8'h00, 1'b0, 1'b0, 8'h40, 4'h6, 1'b1, 1'b0}; // grant 6
    vecs[21] = '{1'b1, 8'h40, 8'h00, 1'b0, 1'b0, 8'h40, 4'h6, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 4'h8, 1'b0, 1'b0}; // reset mid-grant
    vecs[23] = '{1'b1, 8'hC0, 8'h00, 1'b1, 1'b0, 8'h80, 4'h7, 1'b1, 1'b0}; // rr after reset: 7
    vecs[24] = '{1'b1, 8'hC0, 8'h00, 1'b1, 1'b0, 8'h80, 4'h7, 1'b1, 1'b0};

    for (int v = 0; v < NV; v++) begin
      rst_n = vecs[v].rst_n;
      req   = vecs[v].req;
      mask  = vecs[v].mask;
      rr_en = vecs[v].rr_en;
      lock  = vecs[v].lock;
      step();
      chk($sformatf("vec%0d", v), g0, i0, b0, t0,
          vecs[v].eg, vecs[v].ei, vecs[v].eb, vecs[v].et);
    end

    // Round-robin rotation with MAX_HOLD=2: each index held 2 cycles,
    // then one RELEASE cycle carrying the timeout pulse.
    rst_n = 1'b0; req = 8'h00; mask = 8'h00; rr_en = 1'b1; lock = 1'b0;
    step();
    rst_n = 1'b1; req = 8'hFF;
    for (int s = 0; s < 9; s++) begin
      e = (7 - s) & 7;
      step();
      chk($sformatf("rr_hold_a%0d", s), g2, i2, b2, t2, one << e, 4'(e), 1'b1, 1'b0);
      step();
      chk($sformatf("rr_hold_b%0d", s), g2, i2, b2, t2, one << e, 4'(e), 1'b1, 1'b0);
      step();
      chk($sformatf("rr_rel%0d", s), g2, i2, b2, t2, 8'h00, 4'h8, 1'b1, 1'b1);
    end

    // Lock with MAX_HOLD=4: no timeout while locked, revoke right after unlock.
    rst_n = 1'b0; req = 8'h00; rr_en = 1'b0; lock = 1'b1;
    step();
    rst_n = 1'b1; req = 8'h01;
    step();
    chk("lock_grant", g4, i4, b4, t4, 8'h01, 4'h0, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("lock_hold%0d", c), g4, i4, b4, t4, 8'h01, 4'h0, 1'b1, 1'b0);
    end
    lock = 1'b0;
    step();
    chk("lock_revoke", g4, i4, b4, t4, 8'h00, 4'h8, 1'b1, 1'b1);
    step();
    chk("lock_regrant", g4, i4, b4, t4, 8'h01, 4'h0, 1'b1, 1'b0);
    req = 8'h00;
    step();
    chk("lock_release", g4, i4, b4, t4, 8'h00, 4'h8, 1'b1, 1'b0);
    step();
    chk("lock_idle", g4, i4, b4, t4, 8'h00, 4'h8, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
